// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encodings for the core control FSM
// Purpose: 3-bit state codes shared by core_ctrl_fsm and the stall/hazard unit.
package core_ctrl_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_INST          = 3'b000,
    ST_MULDIV        = 3'b001,
    ST_TRAP_MSTATUS  = 3'b010,
    ST_TRAP_MEPC_SET = 3'b011,
    ST_TRAP_MTVEC    = 3'b100,
    ST_TRAP_MEPC_RET = 3'b101,
    ST_TRAP_INT      = 3'b110,
    ST_SLEEP         = 3'b111
  } ctrl_state_e;

endpackage

// File: rtl/core_ctrl_fsm.sv
// rtl/core_ctrl_fsm.sv - core control FSM: MUL/DIV, WFI sleep, trap entry and MRET
// Purpose: sequences multi-cycle operations and trap entry/return between
//   decode and the stall unit; all strobes are Moore-decoded from curr_state.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   dec_valid/dec_stall             decode has an instruction / is stalled
//   dec_is_muldiv/wfi/mret          decoded instruction class
//   dec_pc [XLEN]                   PC of the instruction in decode
//   dec_intr_en                     an interrupt may be taken now
//   int0, int1                      level interrupt lines, int0 has priority
//   mul_rdy, div_rdy                multi-cycle unit result valid
//   curr_state [3]                  registered state code to the stall unit
//   muldiv_act                      MUL/DIV in flight
//   mstatus_enter/mstatus_exit      mstatus update strobes
//   mepc_we, mepc_wdata [XLEN]      mepc write strobe and captured PC
//   pc_ld_mtvec, pc_ld_mepc         fetch redirect strobes
//   pipe_flush                      flush fetch/decode
//   int_ack, int_id                 interrupt acknowledge and acked source
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  input  logic            dec_stall,
  input  logic            dec_is_muldiv,
  input  logic            dec_is_wfi,
  input  logic            dec_is_mret,
  input  logic [XLEN-1:0] dec_pc,
  input  logic            dec_intr_en,
  input  logic            int0,
  input  logic            int1,
  input  logic            mul_rdy,
  input  logic            div_rdy,
  output logic [2:0]      curr_state,
  output logic            muldiv_act,
  output logic            mstatus_enter,
  output logic            mstatus_exit,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic            pc_ld_mtvec,
  output logic            pc_ld_mepc,
  output logic            pipe_flush,
  output logic            int_ack,
  output logic            int_id
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  // The trap is only ever entered from INST, so that is the one place the
  // return PC and source id are captured; they then hold through the sequence.
  logic take_trap;
  assign take_trap = (state_q == ST_INST) && dec_intr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INST;
      mepc_wdata <= '0;
      int_id     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_trap) begin
        mepc_wdata <= dec_pc;
        int_id     <= ~int0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INST: begin
        if (dec_intr_en)                  state_d = ST_TRAP_MSTATUS;
        else if (dec_stall || !dec_valid) state_d = ST_INST;
        else if (dec_is_muldiv)           state_d = ST_MULDIV;
        else if (dec_is_mret)             state_d = ST_TRAP_MEPC_RET;
        else if (dec_is_wfi)              state_d = ST_SLEEP;
      end
      ST_MULDIV:        if (mul_rdy || div_rdy) state_d = ST_INST;
      ST_TRAP_MSTATUS:  state_d = ST_TRAP_MEPC_SET;
      ST_TRAP_MEPC_SET: state_d = ST_TRAP_MTVEC;
      ST_TRAP_MTVEC:    state_d = ST_TRAP_INT;
      ST_TRAP_INT:      state_d = ST_INST;
      ST_TRAP_MEPC_RET: state_d = ST_INST;
      // Wake only; the trap itself is taken from INST via dec_intr_en.
      ST_SLEEP:         if (int0 || int1) state_d = ST_INST;
      default:          state_d = ST_INST;
    endcase
  end

  always_comb begin
    muldiv_act    = 1'b0;
    mstatus_enter = 1'b0;
    mstatus_exit  = 1'b0;
    mepc_we       = 1'b0;
    pc_ld_mtvec   = 1'b0;
    pc_ld_mepc    = 1'b0;
    pipe_flush    = 1'b0;
    int_ack       = 1'b0;
    case (state_q)
      ST_MULDIV:        muldiv_act = 1'b1;
      ST_TRAP_MSTATUS: begin
        mstatus_enter = 1'b1;
        pipe_flush    = 1'b1;
      end
      ST_TRAP_MEPC_SET: mepc_we = 1'b1;
      ST_TRAP_MTVEC: begin
        pc_ld_mtvec = 1'b1;
        pipe_flush  = 1'b1;
      end
      ST_TRAP_INT:      int_ack = 1'b1;
      ST_TRAP_MEPC_RET: begin
        mstatus_exit = 1'b1;
        pc_ld_mepc   = 1'b1;
        pipe_flush   = 1'b1;
      end
      default: ;
    endcase
  end

  assign curr_state = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb/tb_core_ctrl_fsm.sv - self-checking bench for core_ctrl_fsm
module tb_core_ctrl_fsm;

  localparam int XLEN = 32;

  // Control-input bit positions packed into one vector for compact tables.
  localparam logic [10:0] C_R   = 11'h400;
  localparam logic [10:0] C_V   = 11'h200;
  localparam logic [10:0] C_ST  = 11'h100;
  localparam logic [10:0] C_MD  = 11'h080;
  localparam logic [10:0] C_RET = 11'h040;
  localparam logic [10:0] C_WFI = 11'h020;
  localparam logic [10:0] C_IEN = 11'h010;
  localparam logic [10:0] C_I0  = 11'h008;
  localparam logic [10:0] C_I1  = 11'h004;
  localparam logic [10:0] C_MR  = 11'h002;
  localparam logic [10:0] C_DR  = 11'h001;
  localparam logic [10:0] C_0   = 11'h000;

  // Expected outputs {muldiv_act, mstatus_enter, mstatus_exit, mepc_we,
  //                   pc_ld_mtvec, pc_ld_mepc, pipe_flush, int_ack}
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_MD    = 8'h80;
  localparam logic [7:0] O_TMS   = 8'h42;
  localparam logic [7:0] O_MEPC  = 8'h10;
  localparam logic [7:0] O_MTVEC = 8'h0A;
  localparam logic [7:0] O_RET   = 8'h26;
  localparam logic [7:0] O_ACK   = 8'h01;

  localparam logic [2:0] S_INST = 3'b000, S_MD = 3'b001, S_TMS = 3'b010,
                         S_MSET = 3'b011, S_MTV = 3'b100, S_RET = 3'b101,
                         S_TINT = 3'b110, S_SLP = 3'b111;

  typedef struct {
    logic [10:0]     ctl;
    logic [XLEN-1:0] pc;
    logic [2:0]      est;
    logic [7:0]      eout;
    logic            cid;
    logic            eid;
    logic            cmepc;
    logic [XLEN-1:0] emepc;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, dec_valid, dec_stall, dec_is_muldiv, dec_is_wfi, dec_is_mret;
  logic [XLEN-1:0] dec_pc;
  logic            dec_intr_en, int0, int1, mul_rdy, div_rdy;
  logic [2:0]      curr_state;
  logic            muldiv_act, mstatus_enter, mstatus_exit, mepc_we;
  logic [XLEN-1:0] mepc_wdata;
  logic            pc_ld_mtvec, pc_ld_mepc, pipe_flush, int_ack, int_id;
  logic [7:0]      outs;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign outs = {muldiv_act, mstatus_enter, mstatus_exit, mepc_we,
                 pc_ld_mtvec, pc_ld_mepc, pipe_flush, int_ack};

  core_ctrl_fsm #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_stall(dec_stall),
    .dec_is_muldiv(dec_is_muldiv), .dec_is_wfi(dec_is_wfi), .dec_is_mret(dec_is_mret),
    .dec_pc(dec_pc), .dec_intr_en(dec_intr_en), .int0(int0), .int1(int1),
    .mul_rdy(mul_rdy), .div_rdy(div_rdy), .curr_state(curr_state),
    .muldiv_act(muldiv_act), .mstatus_enter(mstatus_enter), .mstatus_exit(mstatus_exit),
    .mepc_we(mepc_we), .mepc_wdata(mepc_wdata), .pc_ld_mtvec(pc_ld_mtvec),
    .pc_ld_mepc(pc_ld_mepc), .pipe_flush(pipe_flush), .int_ack(int_ack), .int_id(int_id)
  );

  function automatic vec_t mk(input logic [10:0] ctl, input logic [XLEN-1:0] pc,
                              input logic [2:0] est, input logic [7:0] eout,
                              input logic cid, input logic eid,
                              input logic cm, input logic [XLEN-1:0] em);
    vec_t v;
    v.ctl = ctl; v.pc = pc; v.est = est; v.eout = eout;
    v.cid = cid; v.eid = eid; v.cmepc = cm; v.emepc = em;
    return v;
  endfunction

  task automatic drive(input logic [10:0] ctl, input logic [XLEN-1:0] pc);
    {rst, dec_valid, dec_stall, dec_is_muldiv, dec_is_mret, dec_is_wfi,
     dec_intr_en, int0, int1, mul_rdy, div_rdy} = ctl;
    dec_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_so(input string name, input logic [2:0] est, input logic [7:0] eout);
    checks++;
    if (curr_state !== est || outs !== eout) begin
      failures++;
      $display("FAIL %s: state=%b outs=%h, required state=%b outs=%h",
               name, curr_state, outs, est, eout);
    end
  endtask

  task automatic chk_id(input string name, input logic eid);
    checks++;
    if (int_id !== eid) begin
      failures++;
      $display("FAIL %s: int_id=%b, required %b", name, int_id, eid);
    end
  endtask

  task automatic chk_mepc(input string name, input logic [XLEN-1:0] em);
    checks++;
    if (mepc_wdata !== em) begin
      failures++;
      $display("FAIL %s: mepc_wdata=%h, required %h", name, mepc_wdata, em);
    end
  endtask

  initial begin
    // reset and first cycle after release
    vecs.push_back(mk(C_R, 0, S_INST, O_NONE, 1, 0, 1, 0));
    vecs.push_back(mk(C_R, 0, S_INST, O_NONE, 1, 0, 1, 0));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // trap with int0 and int1 both high: int0 wins
    vecs.push_back(mk(C_V|C_IEN|C_I0|C_I1, 32'h100, S_TMS, O_TMS, 1, 0, 1, 32'h100));
    vecs.push_back(mk(C_I0|C_I1, 0, S_MSET, O_MEPC, 0, 0, 1, 32'h100));
    vecs.push_back(mk(C_0, 0, S_MTV, O_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_TINT, O_ACK, 1, 0, 1, 32'h100));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // int1 only, dropped while in TRAP_MEPC_SET
    vecs.push_back(mk(C_V|C_IEN|C_I1, 32'h200, S_TMS, O_TMS, 1, 1, 1, 32'h200));
    vecs.push_back(mk(C_I1, 0, S_MSET, O_MEPC, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_MTV, O_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_TINT, O_ACK, 1, 1, 1, 32'h200));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // mret
    vecs.push_back(mk(C_V|C_RET, 0, S_RET, O_RET, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // interrupt beats every decoded opcode
    vecs.push_back(mk(C_V|C_MD|C_RET|C_WFI|C_IEN|C_I0, 32'h300, S_TMS, O_TMS, 1, 0, 1, 32'h300));
    vecs.push_back(mk(C_0, 0, S_MSET, O_MEPC, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_MTV, O_MTVEC, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_TINT, O_ACK, 1, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // stall / invalid decode hold INST
    vecs.push_back(mk(C_V|C_ST|C_WFI, 0, S_INST, O_NONE, 0, 0, 0, 0));
    vecs.push_back(mk(C_WFI, 0, S_INST, O_NONE, 0, 0, 0, 0));
    vecs.push_back(mk(C_V|C_ST|C_MD, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // muldiv beats mret/wfi; interrupts ignored in MULDIV
    vecs.push_back(mk(C_V|C_MD|C_RET|C_WFI, 0, S_MD, O_MD, 0, 0, 0, 0));
    vecs.push_back(mk(C_IEN|C_I0, 0, S_MD, O_MD, 0, 0, 0, 0));
    vecs.push_back(mk(C_MR, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // mret beats wfi
    vecs.push_back(mk(C_V|C_RET|C_WFI, 0, S_RET, O_RET, 0, 0, 0, 0));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));
    // interrupt beats stall, then reset mid-trap clears captures
    vecs.push_back(mk(C_V|C_ST|C_IEN|C_I1, 32'h400, S_TMS, O_TMS, 1, 1, 1, 32'h400));
    vecs.push_back(mk(C_R, 0, S_INST, O_NONE, 1, 0, 1, 0));
    vecs.push_back(mk(C_0, 0, S_INST, O_NONE, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].pc);
      step();
      chk_so($sformatf("vec%0d", i), vecs[i].est, vecs[i].eout);
      if (vecs[i].cid)   chk_id($sformatf("vec%0d_id", i), vecs[i].eid);
      if (vecs[i].cmepc) chk_mepc($sformatf("vec%0d_mepc", i), vecs[i].emepc);
    end

    // MULDIV: active cycles 1..34, div_rdy in cycle 34, INST at 35
    drive(C_V|C_MD, 0);
    step();
    drive(C_0, 0);
    for (int c = 1; c <= 34; c++) begin
      chk_so($sformatf("muldiv_c%0d", c), S_MD, O_MD);
      if (c == 34) drive(C_DR, 0);
      step();
    end
    chk_so("muldiv_done", S_INST, O_NONE);

    // SLEEP for 50 cycles, int1 wakes, trap then taken from INST
    drive(C_V|C_WFI, 0);
    step();
    chk_so("sleep_enter", S_SLP, O_NONE);
    drive(C_0, 0);
    for (int c = 0; c < 50; c++) begin
      step();
      chk_so($sformatf("sleep_c%0d", c), S_SLP, O_NONE);
    end
    drive(C_I1, 0);
    step();
    chk_so("sleep_wake", S_INST, O_NONE);
    drive(C_V|C_IEN|C_I1, 32'h500);
    step();
    chk_so("wake_trap", S_TMS, O_TMS);
    chk_id("wake_trap_id", 1'b1);
    chk_mepc("wake_trap_mepc", 32'h500);
    drive(C_0, 0);
    step(); chk_so("wake_mset", S_MSET, O_MEPC);
    step(); chk_so("wake_mtvec", S_MTV, O_MTVEC);
    step(); chk_so("wake_ack", S_TINT, O_ACK);
    chk_id("wake_ack_id", 1'b1);
    step(); chk_so("wake_done", S_INST, O_NONE);

    // reset held 2 cycles from SLEEP with an interrupt pending
    drive(C_V|C_WFI, 0);
    step();
    chk_so("pre_rst_sleep", S_SLP, O_NONE);
    drive(C_R|C_I0|C_V|C_MD, 0);
    step();
    step();
    drive(C_0, 0);
    step();
    chk_so("post_rst", S_INST, O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
